// File: rtl/pipelined_mult_rr_arbiter.sv
// rtl/pipelined_mult_rr_arbiter.sv - round-robin front end sharing one pipelined multiplier
// Products return on RES_* with the owning requester ID, tracked by a tag pipe of matched depth.
module pipelined_mult_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int OP_W     = 18,
    parameter int MULT_LAT = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [NUM_REQ*OP_W-1:0] i_req_a,
    input  logic [NUM_REQ*OP_W-1:0] i_req_b,
    output logic [OP_W-1:0]         o_mul_a,
    output logic [OP_W-1:0]         o_mul_b,
    input  logic [2*OP_W-1:0]       i_mul_p,
    output logic                    o_res_valid,
    output logic [ID_W-1:0]         o_res_id,
    output logic [2*OP_W-1:0]       o_res_p,
    output logic                    o_busy
);

    localparam int IW = ID_W + 1;

    logic [ID_W-1:0]     r_ptr;
    logic [OP_W-1:0]     r_mul_a;
    logic [OP_W-1:0]     r_mul_b;
    logic [MULT_LAT:0]   r_tag_valid;
    logic [ID_W-1:0]     r_tag_id [0:MULT_LAT];

    logic [IW-1:0]       w_idx;
    logic                w_found;
    logic                w_xfer;
    logic [ID_W-1:0]     w_gnt_id;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [NUM_REQ-1:0]  w_grant;
    logic [OP_W-1:0]     w_sel_a;
    logic [OP_W-1:0]     w_sel_b;

    // Search ptr, ptr+1, ... wrapping at NUM_REQ; first valid index wins.
    always_comb begin
        w_idx    = '0;
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + IW'(k);
            if (w_idx >= IW'(NUM_REQ)) begin
                w_idx = w_idx - IW'(NUM_REQ);
            end
            if (!w_found && i_req_valid[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[ID_W-1:0];
            end
        end
    end

    assign w_xfer    = w_found & i_rst_n;
    assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
    assign w_sel_a   = i_req_a[w_gnt_id*OP_W +: OP_W];
    assign w_sel_b   = i_req_b[w_gnt_id*OP_W +: OP_W];

    always_comb begin
        w_grant = '0;
        if (w_xfer) begin
            w_grant[w_gnt_id] = 1'b1;
        end
    end

    // Reset clears every tag valid, so products already inside the multiplier are dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_tag_valid <= '0;
            for (int s = 0; s <= MULT_LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_valid <= {r_tag_valid[MULT_LAT-1:0], w_xfer};
            r_tag_id[0] <= w_xfer ? w_gnt_id : '0;
            for (int s = 1; s <= MULT_LAT; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
            if (w_xfer) begin
                r_ptr   <= w_ptr_nxt;
                r_mul_a <= w_sel_a;
                r_mul_b <= w_sel_b;
            end
        end
    end

    assign o_req_ready = w_grant;
    assign o_mul_a     = r_mul_a;
    assign o_mul_b     = r_mul_b;
    assign o_res_valid = r_tag_valid[MULT_LAT];
    assign o_res_id    = r_tag_id[MULT_LAT];
    assign o_res_p     = i_mul_p;
    assign o_busy      = |r_tag_valid;

endmodule
